theta_stage: RTL and testbench

Slice-serial theta step of the permutation datapath. It reads the 64×25 state one slice (`z`) at a time from the upstream state memory and writes theta-mixed slices to the memory that the downstream rotate stage consumes. The block runs one full 64-slice pass per `start` pulse and signals completion with `done`. Processing is slice-serial, so the column parity of slice `z-1` is carried in a register. Slice 63 is pre-read so that slice 0 wraps correctly.

---
 rtl/theta_pkg.sv | 27 ++
 rtl/theta_stage_slice_comb.sv | 35 +++
 rtl/theta_stage.sv | 150 +++++++++++++++
 tb/tb_theta_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/theta_pkg.sv
// theta_pkg
// Shared definitions for the slice-serial theta stage.
//   SLICE_W       : bits per slice (5x5 lanes, bit index 5*y + x)
//   DEPTH         : slices per state
//   ADDR_W        : slice address width
//   theta_state_t : controller states
//   bit_idx(x,y)  : position of lane (x,y) inside a slice
package theta_pkg;

  localparam int SLICE_W = 25;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;
  localparam int LANES   = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } theta_state_t;

  function automatic int bit_idx(input int x, input int y);
    return LANES * y + x;
  endfunction

endpackage

// File: rtl/theta_stage_slice_comb.sv
// theta_slice_comb
// Purely combinational theta for one slice.
// Ports:
//   slice    [25] in  : slice z, bit index 5*y + x
//   prev_par [5]  in  : column parity of slice z-1
//   out      [25] out : theta-mixed slice z
//   par      [5]  out : column parity of slice z (becomes prev_par for z+1)
module theta_slice_comb
  import theta_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  input  logic [LANES-1:0]   prev_par,
  output logic [SLICE_W-1:0] out,
  output logic [LANES-1:0]   par
);

  always_comb begin
    par = '0;
    out = '0;
    for (int x = 0; x < LANES; x++) begin
      for (int y = 0; y < LANES; y++) begin
        par[x] = par[x] ^ slice[bit_idx(x, y)];
      end
    end
    // Left neighbour column from this slice, right neighbour column from z-1.
    for (int x = 0; x < LANES; x++) begin
      for (int y = 0; y < LANES; y++) begin
        out[bit_idx(x, y)] = slice[bit_idx(x, y)]
                           ^ par[(x + 4) % LANES]
                           ^ prev_par[(x + 1) % LANES];
      end
    end
  end

endmodule

// File: rtl/theta_stage.sv
// theta_stage
// Slice-serial theta step: reads one slice per cycle from the upstream
// memory and writes theta-mixed slices downstream, one 64-slice pass per
// start pulse. Slice 63 is read first so its parity is available when
// slice 0 is processed.
// Optional feature macro: THETA_BYPASS_EN adds the bypass port; a pass
// started with bypass high copies rd_data to wr_data unchanged.
// Ports:
//   clk      in  : rising-edge clock
//   rst      in  : synchronous active-high reset
//   start    in  : begin a pass (only honoured in IDLE)
//   rd_addr  out : upstream slice address (synchronous read, data next cycle)
//   rd_data  in  : slice for the previous cycle's rd_addr
//   wr_en    out : downstream write strobe
//   wr_addr  out : downstream slice index
//   wr_data  out : theta-mixed slice
//   busy     out : high in every state except IDLE
//   done     out : one-cycle pulse after the last write
//   bypass   in  : (THETA_BYPASS_EN only) copy mode, latched with start
//
// state | meaning
// IDLE  | waiting for start
// PRIME | rd_addr=63 issued so slice 63 parity can seed the wrap
// RUN   | rd_addr 0..63 issued; first data cycle only latches parity
// DRAIN | writes slice 63, then one cycle for the write to retire
// DONE  | done pulse visible; back to IDLE
module theta_stage #(
  parameter int SLICE_W = theta_pkg::SLICE_W,
  parameter int DEPTH   = theta_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  input  logic [SLICE_W-1:0]         rd_data,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [SLICE_W-1:0]         wr_data,
  output logic                       busy,
`ifdef THETA_BYPASS_EN
  input  logic                       bypass,
`endif
  output logic                       done
);

  import theta_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  theta_state_t        state;
  logic [AW-1:0]       wr_ptr;
  logic [LANES-1:0]    prev_par;
  logic                drain_last;
  logic [SLICE_W-1:0]  slice_out;
  logic [LANES-1:0]    slice_par;
  logic [SLICE_W-1:0]  wr_next;

  theta_slice_comb u_comb (
    .slice    (rd_data),
    .prev_par (prev_par),
    .out      (slice_out),
    .par      (slice_par)
  );

`ifdef THETA_BYPASS_EN
  logic bypass_q;
  assign wr_next = bypass_q ? rd_data : slice_out;
`else
  assign wr_next = slice_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_ptr     <= '0;
      prev_par   <= '0;
      drain_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef THETA_BYPASS_EN
      bypass_q   <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= PRIME;
            rd_addr <= LAST_ADDR;
            wr_ptr  <= '0;
            busy    <= 1'b1;
`ifdef THETA_BYPASS_EN
            bypass_q <= bypass;
`endif
          end
        end
        PRIME: begin
          state   <= RUN;
          rd_addr <= '0;
        end
        RUN: begin
          // rd_data holds slice rd_addr-1; at rd_addr==0 it is slice 63,
          // which only seeds the parity register.
          if (rd_addr != '0) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_ptr;
            wr_data <= wr_next;
            wr_ptr  <= wr_ptr + 1'b1;
          end
          prev_par <= slice_par;
          if (rd_addr == LAST_ADDR) begin
            state      <= DRAIN;
            drain_last <= 1'b0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (!drain_last) begin
            // rd_addr is held at 63, so rd_data is still slice 63.
            wr_en      <= 1'b1;
            wr_addr    <= wr_ptr;
            wr_data    <= wr_next;
            wr_ptr     <= wr_ptr + 1'b1;
            prev_par   <= slice_par;
            drain_last <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_theta_stage.sv
module tb_theta_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  rd_addr;
  logic [24:0] rd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
  logic        busy;
  logic        done;
`ifdef THETA_BYPASS_EN
  logic        bypass;
`endif

  always #5 clk = ~clk;

  theta_stage dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
`ifdef THETA_BYPASS_EN
    .bypass  (bypass),
`endif
    .done    (done)
  );

  logic [24:0] mem [64];
  logic [24:0] exp_data [64];

  always @(posedge clk) rd_data <= mem[rd_addr];

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          rel;
    logic [5:0]  addr;
    logic [24:0] data;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every write must match the next expected entry.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_cycle", 32'(cyc - base + 1), 32'(e.rel));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  function automatic logic [4:0] col_par(input logic [24:0] s);
    logic [4:0] p;
    p = '0;
    for (int x = 0; x < 5; x++)
      p[x] = s[x] ^ s[x + 5] ^ s[x + 10] ^ s[x + 15] ^ s[x + 20];
    return p;
  endfunction

  task automatic model_all();
    for (int z = 0; z < 64; z++) begin
      logic [4:0]  c, cp;
      logic [24:0] r;
      c  = col_par(mem[z]);
      cp = col_par(mem[(z + 63) % 64]);
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          r[5*y + x] = mem[z][5*y + x] ^ c[(x + 4) % 5] ^ cp[(x + 1) % 5];
      exp_data[z] = r;
    end
  endtask

  task automatic clear_state();
    for (int z = 0; z < 64; z++) begin
      mem[z] = '0;
      exp_data[z] = '0;
    end
  endtask

  // glitch: relative cycle at which a stray start is pulsed (0 = none)
  // rst_at: relative cycle during which rst is raised (0 = none)
  task automatic run_pass(input int glitch, input int rst_at);
    int n_writes;
    int done_rel;
    n_writes = (rst_at != 0) ? (rst_at - 3) : 64;
    for (int i = 0; i < n_writes; i++) begin
      exp_t e;
      e.rel  = 4 + i;
      e.addr = 6'(i);
      e.data = exp_data[i];
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base  = cyc;
    start = 1'b0;
    done_rel = 0;
    for (int r = 1; r <= 75; r++) begin
      @(negedge clk);
      if (r == 1) begin
        chk("busy_prime", 32'(busy), 32'd1);
        chk("rd_addr_prime", 32'(rd_addr), 32'd63);
      end
      if (r == 2) chk("rd_addr_first", 32'(rd_addr), 32'd0);
      if (r == 65 && rst_at == 0) chk("rd_addr_last", 32'(rd_addr), 32'd63);
      if (done === 1'b1 && done_rel == 0) done_rel = r;
      if (rst_at == 0 && r == 68) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
      end
      if (rst_at == 0 && r == 69) begin
        chk("done_low_after", 32'(done), 32'd0);
        chk("busy_low_after", 32'(busy), 32'd0);
      end
      if (rst_at != 0 && r == rst_at + 1) begin
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        rst = 1'b0;
      end
      if (rst_at != 0 && r == rst_at) rst = 1'b1;
      start = (r == glitch);
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_rel), (rst_at != 0) ? 32'd0 : 32'd68);
    chk("busy_idle_end", 32'(busy), 32'd0);
    chk("all_writes_seen", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
`ifdef THETA_BYPASS_EN
    bypass = 1'b0;
`endif
    clear_state();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    // All-zero state.
    clear_state();
    run_pass(0, 0);

    // Single bit in slice 0.
    clear_state();
    mem[0] = 25'h0000001;
    exp_data[0] = 25'h0210843;
    exp_data[1] = 25'h1084210;
    run_pass(0, 0);

    // Single bit in slice 63 exercises the wrap into slice 0.
    clear_state();
    mem[63] = 25'h0000001;
    exp_data[0]  = 25'h1084210;
    exp_data[63] = 25'h0210843;
    run_pass(0, 0);

    // Random state with a stray start mid-pass.
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    model_all();
    run_pass(10, 0);

    // Reset mid-pass, then a clean full pass.
    run_pass(0, 30);
    run_pass(0, 0);

`ifdef THETA_BYPASS_EN
    for (int z = 0; z < 64; z++) begin
      mem[z] = 25'($urandom);
      exp_data[z] = mem[z];
    end
    bypass = 1'b1;
    run_pass(0, 0);
    bypass = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
